// File: rtl/relogio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : relogio_pkg
// Purpose  : Shared types, limits and BCD helpers for the HH:MM:SS counter.
// Contents : estado_t        - FSM state encoding (RUN / SET_HORA / SET_MIN)
//            HORA_MAX, MIN_MAX, SEG_MAX - field limits (decimal)
//            para_bcd()      - decimal 0..99 to packed two-digit BCD
//            bcd_inc()       - two-digit BCD increment, wrapping max -> 00
// Revision : 1.0 - initial release
// ============================================================================
package relogio_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HORA = 2'd1,
    SET_MIN  = 2'd2
  } estado_t;

  localparam int unsigned HORA_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEG_MAX  = 59;

  // {tens, units} packed as two nibbles
  function automatic logic [7:0] para_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Wraps to 00 exactly at max_val; units roll 9 -> 0 with a carry into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int unsigned max_val);
    if (v == para_bcd(max_val)) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/relogio_contador_hms_sincronizador_borda.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador_borda
// Purpose  : Brings an asynchronous level into the clk_in domain and turns
//            each synchronised rising edge into a one-cycle pulse.
// Ports    : clk_in - system clock
//            rst    - asynchronous active-low reset
//            d      - asynchronous level input
//            pulso  - one-cycle pulse per rising edge of d
// Revision : 1.0 - initial release
// ============================================================================
module sincronizador_borda #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic pulso
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_hist <= r_sync[STAGES-1];
    end
  end

  // A held-high level yields a single pulse; re-arms only once a low is seen.
  assign pulso = r_sync[STAGES-1] & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/relogio_contador_hms.sv
`default_nettype none
// ============================================================================
// Module   : relogio_contador_hms
// Purpose  : 24 h BCD clock counter driven by the 1 Hz divider output, with
//            manual hour/minute setting through two debounced buttons.
// Ports    : clk_in    - system clock (50 MHz)
//            rst       - asynchronous active-low reset
//            tick_in   - 1 Hz square wave, rising edges advance the time
//            btn_modo  - mode button (RUN -> SET_HORA -> SET_MIN -> RUN)
//            btn_inc   - increment button for the field being set
//            hora_dez/hora_uni, min_dez/min_uni, seg_dez/seg_uni - BCD digits
//            modo      - current state (0 RUN, 1 SET_HORA, 2 SET_MIN)
//            seg_pulso - one-cycle pulse in the cycle after a RUN advance
// Revision : 1.0 - initial release
// ============================================================================
module relogio_contador_hms
  import relogio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int INC_RAPIDO  = 0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_modo,
  input  logic       btn_inc,
  output logic [1:0] hora_dez,
  output logic [3:0] hora_uni,
  output logic [2:0] min_dez,
  output logic [3:0] min_uni,
  output logic [2:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic [1:0] modo,
  output logic       seg_pulso
);

  logic w_tick_pulso;
  logic w_modo_pulso;
  logic w_inc_pulso;
  logic w_inc;

  estado_t    r_estado;
  logic [7:0] r_hora;
  logic [7:0] r_min;
  logic [7:0] r_seg;
  logic       r_seg_pulso;

  sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sync_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (tick_in),
    .pulso  (w_tick_pulso)
  );

  sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sync_modo (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (btn_modo),
    .pulso  (w_modo_pulso)
  );

  sincronizador_borda #(.STAGES(SYNC_STAGES)) u_sync_inc (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (btn_inc),
    .pulso  (w_inc_pulso)
  );

  // OR-ing the sources means a coincident tick and button give a single +1.
  assign w_inc = w_inc_pulso | ((INC_RAPIDO != 0) & w_tick_pulso);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      r_estado    <= RUN;
      r_hora      <= 8'h00;
      r_min       <= 8'h00;
      r_seg       <= 8'h00;
      r_seg_pulso <= 1'b0;
    end else begin
      r_seg_pulso <= 1'b0;
      case (r_estado)
        RUN: begin
          if (w_tick_pulso) begin
            r_seg       <= bcd_inc(r_seg, SEG_MAX);
            r_seg_pulso <= 1'b1;
            if (r_seg == para_bcd(SEG_MAX)) begin
              r_min <= bcd_inc(r_min, MIN_MAX);
              if (r_min == para_bcd(MIN_MAX)) begin
                r_hora <= bcd_inc(r_hora, HORA_MAX);
              end
            end
          end
          if (w_modo_pulso) begin
            r_estado <= SET_HORA;
          end
        end
        SET_HORA: begin
          if (w_inc) begin
            r_hora <= bcd_inc(r_hora, HORA_MAX);
          end
          if (w_modo_pulso) begin
            r_estado <= SET_MIN;
          end
        end
        SET_MIN: begin
          if (w_inc) begin
            r_min <= bcd_inc(r_min, MIN_MAX);
          end
          if (w_modo_pulso) begin
            r_estado <= RUN;
            r_seg    <= 8'h00;
          end
        end
        default: begin
          r_estado <= RUN;
        end
      endcase
    end
  end

  assign hora_dez  = r_hora[5:4];
  assign hora_uni  = r_hora[3:0];
  assign min_dez   = r_min[6:4];
  assign min_uni   = r_min[3:0];
  assign seg_dez   = r_seg[6:4];
  assign seg_uni   = r_seg[3:0];
  assign modo      = r_estado;
  assign seg_pulso = r_seg_pulso;

endmodule
`default_nettype wire

// File: tb/tb_relogio_contador_hms.sv
`default_nettype none
// ============================================================================
// Module   : tb_relogio_contador_hms
// Purpose  : Self-checking bench for relogio_contador_hms with a time-of-day
//            reference model and directed plus randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relogio_contador_hms;

  localparam int S = 2;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       tick_in = 1'b0;
  logic       btn_modo = 1'b0;
  logic       btn_inc = 1'b0;
  logic [1:0] hora_dez;
  logic [3:0] hora_uni;
  logic [2:0] min_dez;
  logic [3:0] min_uni;
  logic [2:0] seg_dez;
  logic [3:0] seg_uni;
  logic [1:0] modo;
  logic       seg_pulso;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  bit chk_en = 1'b0;

  relogio_contador_hms #(.SYNC_STAGES(S), .INC_RAPIDO(0)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .tick_in   (tick_in),
    .btn_modo  (btn_modo),
    .btn_inc   (btn_inc),
    .hora_dez  (hora_dez),
    .hora_uni  (hora_uni),
    .min_dez   (min_dez),
    .min_uni   (min_uni),
    .seg_dez   (seg_dez),
    .seg_uni   (seg_uni),
    .modo      (modo),
    .seg_pulso (seg_pulso)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- reference model: time kept as plain integers ----------
  int m_hh, m_mm, m_ss, m_mode;
  bit m_pulse;
  bit tq[$], mq[$], iq[$];   // input samples, oldest first

  task automatic model_reset();
    m_hh = 0; m_mm = 0; m_ss = 0; m_mode = 0; m_pulse = 0;
    tq.delete(); mq.delete(); iq.delete();
    for (int k = 0; k < S + 1; k++) begin
      tq.push_back(1'b0); mq.push_back(1'b0); iq.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit t, m, i;
    int tot;
    tq.push_back(tick_in); mq.push_back(btn_modo); iq.push_back(btn_inc);
    // An edge acts S clock edges after it is first sampled.
    t = tq[1] && !tq[0];
    m = mq[1] && !mq[0];
    i = iq[1] && !iq[0];
    void'(tq.pop_front()); void'(mq.pop_front()); void'(iq.pop_front());
    m_pulse = 0;
    case (m_mode)
      0: begin
        if (t) begin
          tot  = (m_hh * 3600 + m_mm * 60 + m_ss + 1) % 86400;
          m_hh = tot / 3600;
          m_mm = (tot / 60) % 60;
          m_ss = tot % 60;
          m_pulse = 1;
        end
        if (m) m_mode = 1;
      end
      1: begin
        if (i) m_hh = (m_hh + 1) % 24;
        if (m) m_mode = 2;
      end
      default: begin
        if (i) m_mm = (m_mm + 1) % 60;
        if (m) begin m_mode = 0; m_ss = 0; end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // ---------------- per-cycle compare against the model ------------------
  logic [22:0] act_v, exp_v;
  initial begin
    forever begin
      @(negedge clk_in);
      pulse_cnt = pulse_cnt + int'(seg_pulso);
      if (chk_en) begin
        act_v = {hora_dez, hora_uni, min_dez, min_uni, seg_dez, seg_uni, modo, seg_pulso};
        exp_v = {2'(m_hh / 10), 4'(m_hh % 10), 3'(m_mm / 10), 4'(m_mm % 10),
                 3'(m_ss / 10), 4'(m_ss % 10), 2'(m_mode), m_pulse};
        n_tests++;
        if (act_v !== exp_v) begin
          n_fail++;
          $display("FAIL model_cmp t=%0t: got %0d%0d:%0d%0d:%0d%0d modo=%0d pulso=%0b, expected %02d:%02d:%02d modo=%0d pulso=%0b",
                   $time, hora_dez, hora_uni, min_dez, min_uni, seg_dez, seg_uni, modo, seg_pulso,
                   m_hh, m_mm, m_ss, m_mode, m_pulse);
        end
      end
    end
  end

  // ---------------- helpers ----------------------------------------------
  function automatic int hms();
    return (int'(hora_dez) * 10 + int'(hora_uni)) * 10000 +
           (int'(min_dez)  * 10 + int'(min_uni))  * 100 +
           (int'(seg_dez)  * 10 + int'(seg_uni));
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic tick();
    tick_in = 1'b1; cyc(3); tick_in = 1'b0; cyc(3);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic press_modo();
    btn_modo = 1'b1; cyc(3); btn_modo = 1'b0; cyc(3);
  endtask

  task automatic press_inc(input int n);
    repeat (n) begin btn_inc = 1'b1; cyc(3); btn_inc = 1'b0; cyc(3); end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
  endtask

  // ---------------- directed + random stimulus ---------------------------
  int p0;
  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    cyc(3);
    chk_en = 1'b1;
    chk("reset_hms", hms(), 0);
    chk("reset_modo", int'(modo), 0);
    rst = 1'b1;
    cyc(2);

    // Three ticks, first one timed edge by edge.
    p0 = pulse_cnt;
    tick_in = 1'b1;
    @(posedge clk_in);               // edge k samples the rise
    @(posedge clk_in); #1;           // edge k+1
    chk("lat_pulso_k1", int'(seg_pulso), 0);
    @(posedge clk_in); #1;           // edge k+2: digits update
    chk("lat_pulso_k2", int'(seg_pulso), 1);
    chk("lat_seg_k2", int'(seg_uni), 1);
    @(negedge clk_in);
    tick_in = 1'b0;
    cyc(3);
    ticks(2);
    chk("three_ticks_seg", hms(), 3);
    chk("three_ticks_pulses", pulse_cnt - p0, 3);

    // Set 23:59:00, count up to midnight.
    press_modo(); press_inc(23);
    press_modo(); press_inc(59);
    press_modo();
    ticks(58);
    chk("set_235958", hms(), 235958);
    tick();
    chk("to_235959", hms(), 235959);
    tick();
    chk("wrap_midnight", hms(), 0);

    // 25 hour increments wrap to 01; ticks in SET_HORA are ignored.
    press_modo(); press_inc(25);
    chk("hora_wrap_25", hms(), 10000);
    ticks(2);
    chk("set_hora_frozen", hms(), 10000);
    chk("set_hora_modo", int'(modo), 1);

    // Reach 12:59:37 in SET_MIN, then minute wrap without hour carry.
    press_modo(); press_modo();
    ticks(37);
    press_modo(); press_inc(11);
    press_modo(); press_inc(59);
    chk("set_125937", hms(), 125937);
    press_inc(1);
    chk("min_wrap_nocarry", hms(), 120037);
    press_modo();
    chk("exit_set_clears_seg", hms(), 120000);
    chk("exit_set_modo", int'(modo), 0);

    // Held increment button: one step only.
    press_modo(); press_modo();
    btn_inc = 1'b1; cyc(1000); btn_inc = 1'b0; cyc(3);
    chk("hold_inc_single", hms(), 120100);
    press_modo();

    // Asynchronous reset mid-count at 05:43:21.
    do_reset();
    press_modo(); press_inc(5);
    press_modo(); press_inc(43);
    press_modo();
    ticks(21);
    chk("pre_async_rst", hms(), 54321);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_hms", hms(), 0);
    chk("async_rst_modo", int'(modo), 0);
    @(negedge clk_in);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    tick();
    chk("resume_after_rst", hms(), 1);

    // Random levels on all inputs, occasional reset pulses.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk_in);
      if ($urandom_range(3) == 0)  tick_in  = ~tick_in;
      if ($urandom_range(11) == 0) btn_modo = ~btn_modo;
      if ($urandom_range(5) == 0)  btn_inc  = ~btn_inc;
      rst = ($urandom_range(999) == 0) ? 1'b0 : 1'b1;
    end
    @(negedge clk_in);
    rst = 1'b1; tick_in = 1'b0; btn_modo = 1'b0; btn_inc = 1'b0;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
